// File: rtl/adc_rx_pack_pkg.sv
// adc_rx_pack shared types: FSM encoding, ADC word layout, limits.
// Optional DC removal is built with ADC_RX_PACK_DC_REMOVE_EN.
package adc_rx_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SAMP_W = 16;
  localparam int I0_LSB = 0;
  localparam int Q0_LSB = 16;
  localparam int I1_LSB = 32;
  localparam int Q1_LSB = 48;

  localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

  localparam int DC_SHIFT = 6;
  localparam int DC_W     = 22;

  function automatic logic [SAMP_W-1:0] sat16(
    input logic signed [DC_W:0] v
  );
    if (v > 23'sd32767)
      return 16'h7FFF;
    else if (v < -23'sd32768)
      return 16'h8000;
    else
      return v[SAMP_W-1:0];
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock show-ahead FIFO: head word is always on rd_data.
// A write into a full FIFO only lands when a read frees a slot.
module rx_sync_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(1) << AW;

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_ok;
  logic         rd_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 2**AW; i++)
        mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/adc_rx_pack.sv
// ADC rx packer: antenna select, decimation, FIFO to rx stream.
// Define ADC_RX_PACK_DC_REMOVE_EN for DC removal (+1 cycle latency).
module adc_rx_pack
  import adc_rx_pack_pkg::*;
#(
  parameter int ADC_PACK_DATA_WIDTH = 64,
  parameter int IQ_WIDTH            = 32,
  parameter int FIFO_AW             = 4
) (
  input  logic                           adc_clk,
  input  logic                           adc_rst,
  input  logic [ADC_PACK_DATA_WIDTH-1:0] adc_data,
  input  logic                           adc_valid,
  output logic                           adc_ovf,
  input  logic                           enable,
  input  logic                           ant_sel,
  input  logic [3:0]                     decim_m1,
  output logic [IQ_WIDTH-1:0]            m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [FIFO_AW:0]               fifo_level,
  output logic [15:0]                    ovf_cnt,
  output logic                           busy
);

  state_t state;
  state_t state_nxt;

  logic                start;
  logic                run;
  logic                ant_sh;
  logic [3:0]          decim_sh;
  logic [3:0]          cnt;
  logic                cap_valid;
  logic [IQ_WIDTH-1:0] cap_data;
  logic                wr_valid;
  logic [IQ_WIDTH-1:0] wr_data;
  logic                pipe_busy;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;

  assign start = (state == ST_IDLE) && enable;
  assign run   = (state == ST_RUN);
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // DRAIN also waits for in-flight pipeline words to land
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)
          state_nxt = ST_RUN;
        else if (fifo_empty && !pipe_busy)
          state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      ant_sh    <= 1'b0;
      decim_sh  <= '0;
      cnt       <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      cap_valid <= run && adc_valid && (cnt == '0);
      if (start) begin
        ant_sh   <= ant_sel;
        decim_sh <= decim_m1;
        cnt      <= '0;
      end else if (run && adc_valid) begin
        cnt <= (cnt == decim_sh) ? 4'd0 : cnt + 4'd1;
        if (cnt == '0)
          cap_data <= ant_sh
            ? {adc_data[Q1_LSB +: SAMP_W], adc_data[I1_LSB +: SAMP_W]}
            : {adc_data[Q0_LSB +: SAMP_W], adc_data[I0_LSB +: SAMP_W]};
      end
    end
  end

`ifdef ADC_RX_PACK_DC_REMOVE_EN
  logic signed [DC_W-1:0]   dc_i;
  logic signed [DC_W-1:0]   dc_q;
  logic signed [SAMP_W-1:0] xi;
  logic signed [SAMP_W-1:0] xq;
  logic signed [DC_W:0]     di;
  logic signed [DC_W:0]     dq;
  logic                     dc_valid;
  logic [IQ_WIDTH-1:0]      dc_data;

  assign xi = cap_data[SAMP_W-1:0];
  assign xq = cap_data[2*SAMP_W-1:SAMP_W];
  assign di = xi - dc_i;
  assign dq = xq - dc_q;

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      dc_i     <= '0;
      dc_q     <= '0;
      dc_valid <= 1'b0;
      dc_data  <= '0;
    end else begin
      dc_valid <= cap_valid;
      if (start) begin
        dc_i <= '0;
        dc_q <= '0;
      end else if (cap_valid) begin
        dc_i    <= dc_i + DC_W'(di >>> DC_SHIFT);
        dc_q    <= dc_q + DC_W'(dq >>> DC_SHIFT);
        dc_data <= {sat16(dq), sat16(di)};
      end
    end
  end

  assign wr_valid  = dc_valid;
  assign wr_data   = dc_data;
  assign pipe_busy = cap_valid || dc_valid;
`else
  assign wr_valid  = cap_valid;
  assign wr_data   = cap_data;
  assign pipe_busy = cap_valid;
`endif

  rx_sync_fifo #(
    .W  (IQ_WIDTH),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (adc_clk),
    .rst     (adc_rst),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign drop    = wr_valid && fifo_full && !pop;

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      adc_ovf <= 1'b0;
      ovf_cnt <= '0;
    end else if (start) begin
      adc_ovf <= 1'b0;
      ovf_cnt <= '0;
    end else if (drop) begin
      adc_ovf <= 1'b1;
      if (ovf_cnt != OVF_CNT_MAX)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_adc_rx_pack.sv
// Scoreboard bench for adc_rx_pack (default build, no DC removal).
// Stimulus pushes expected words; a negedge monitor checks each pop.
module tb_adc_rx_pack;

  logic        adc_clk;
  logic        adc_rst;
  logic [63:0] adc_data;
  logic        adc_valid;
  logic        adc_ovf;
  logic        enable;
  logic        ant_sel;
  logic [3:0]  decim_m1;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_cnt;
  logic        busy;

  adc_rx_pack dut (
    .adc_clk    (adc_clk),
    .adc_rst    (adc_rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .adc_ovf    (adc_ovf),
    .enable     (enable),
    .ant_sel    (ant_sel),
    .decim_m1   (decim_m1),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pops = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic [31:0] exp_q [$];

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;
  always @(posedge adc_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a handshake seen at negedge completes on the next posedge
  always @(negedge adc_clk) begin
    if (!adc_rst) begin
      if (m_valid && !prev_valid && rise_cyc < 0)
        rise_cyc = cyc;
      prev_valid = m_valid;
      if (m_valid && m_ready) begin
        pops++;
        if (exp_q.size() == 0)
          chk("unexpected_out", m_data, 32'hxxxx_xxxx);
        else
          chk("m_data", m_data, exp_q.pop_front());
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [15:0] i0,
    input logic [15:0] q0, input logic [15:0] i1, input logic [15:0] q1);
    return {q1, i1, q0, i0};
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++)
      tick();
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++)
      tick();
    chk("idle_busy", {31'd0, busy}, 0);
  endtask

  task automatic send(input logic [63:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int p0;
    logic [15:0] k;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int p0;
    logic [15:0] k;
    adc_rst   = 1'b1;
    adc_data  = '0;
    adc_valid = 1'b0;
    enable    = 1'b0;
    ant_sel   = 1'b0;
    decim_m1  = '0;
    m_ready   = 1'b0;
    tick();
    tick();
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_level", {27'd0, fifo_level}, 0);
    chk("rst_ovf_cnt", {16'd0, ovf_cnt}, 0);
    chk("rst_adc_ovf", {31'd0, adc_ovf}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    adc_rst = 1'b0;
    tick();

    // Basic capture, antenna 0, no decimation
    enable  = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("run_busy", {31'd0, busy}, 1);
    c0 = cyc;
    for (int j = 0; j < 8; j++) begin
      k = 16'(j);
      exp_q.push_back({16'h0100 + k, k});
      adc_data  = mk(k, 16'h0100 + k, 16'hEEEE, 16'hDDDD);
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
    wait_drain();
    chk("latency", rise_cyc - c0, 2);
    chk("basic_ovf", {31'd0, adc_ovf}, 0);
    chk("basic_ovf_cnt", {16'd0, ovf_cnt}, 0);

    // Antenna 1, decimate by 4, config change mid-run ignored
    enable = 1'b0;
    wait_idle();
    ant_sel  = 1'b1;
    decim_m1 = 4'd3;
    enable   = 1'b1;
    tick();
    p0 = pops;
    for (int j = 0; j < 16; j++) begin
      k = 16'(j);
      if (j == 8) begin
        decim_m1 = 4'd0;
        ant_sel  = 1'b0;
      end
      if (j % 4 == 0)
        exp_q.push_back({16'h0200 + k, k});
      adc_data  = mk(16'hA000 + k, 16'hB000 + k, k, 16'h0200 + k);
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
    wait_drain();
    tick();
    tick();
    chk("decim_count", pops - p0, 4);

    // Backpressure: 20 kept samples, 4 dropped
    enable = 1'b0;
    wait_idle();
    m_ready = 1'b0;
    enable  = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      k = 16'(j);
      if (j < 16)
        exp_q.push_back({16'h0100 + k, k});
      adc_data  = mk(k, 16'h0100 + k, 16'h5555, 16'h6666);
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
    tick();
    tick();
    chk("bp_level", {27'd0, fifo_level}, 16);
    chk("bp_adc_ovf", {31'd0, adc_ovf}, 1);
    chk("bp_ovf_cnt", {16'd0, ovf_cnt}, 4);
    chk("bp_head", m_data, 32'h0100_0000);

    // Full FIFO: write coincides with a single pop
    exp_q.push_back({16'h0114, 16'h0014});
    send(mk(16'h0014, 16'h0114, 16'h0, 16'h0));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("fullpop_level", {27'd0, fifo_level}, 16);
    chk("fullpop_ovf_cnt", {16'd0, ovf_cnt}, 4);
    m_ready = 1'b1;
    wait_drain();

    // Drain: 5 entries queued when enable falls
    m_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      k = 16'h0030 + 16'(j);
      exp_q.push_back({16'h0100 + k, k});
      send(mk(k, 16'h0100 + k, 16'h0, 16'h0));
    end
    tick();
    tick();
    enable = 1'b0;
    tick();
    tick();
    chk("drain_busy0", {31'd0, busy}, 1);
    chk("drain_level", {27'd0, fifo_level}, 5);
    p0 = pops;
    m_ready = 1'b1;
    for (int i = 0; i < 50 && busy; i++) begin
      tick();
      if (fifo_level != 0)
        chk("drain_busy", {31'd0, busy}, 1);
    end
    chk("drain_idle", {31'd0, busy}, 0);
    chk("drain_pops", pops - p0, 5);
    chk("drain_empty", {27'd0, fifo_level}, 0);

    // Asynchronous reset mid-stream with overflow pending
    m_ready = 1'b0;
    enable  = 1'b1;
    tick();
    for (int j = 0; j < 18; j++) begin
      k = 16'(j);
      adc_data  = mk(k, k, k, k);
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_ovf_cnt", {16'd0, ovf_cnt}, 2);
    chk("pre_rst_m_valid", {31'd0, m_valid}, 1);
    #2;
    adc_rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_m_valid", {31'd0, m_valid}, 0);
    chk("arst_level", {27'd0, fifo_level}, 0);
    chk("arst_ovf_cnt", {16'd0, ovf_cnt}, 0);
    chk("arst_adc_ovf", {31'd0, adc_ovf}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    enable = 1'b0;
    tick();
    adc_rst = 1'b0;
    tick();
    tick();
    chk("post_rst_busy", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_rx_pack.md
Name: adc_rx_pack

Overview:
- Receive-side counterpart of the DAC transmit interface. Lives entirely in the ADC clock domain.
- Takes the packed 2-antenna ADC word, selects one antenna and decimates by a programmable factor.
- Buffers IQ samples in a small synchronous FIFO and presents them to the rx accelerator over a valid/ready stream.
- Reports overflow back to the ADC core as a sticky flag and a saturating counter.

Parameters:
- ADC_PACK_DATA_WIDTH, 64: packed ADC word width; fixed layout {Q1,I1,Q0,I0}, 16 bits each.
- IQ_WIDTH, 32: output sample width; {Q,I}.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW = 16.

Ports:
- adc_clk  in  1  sole clock.
- adc_rst  in  1  reset; asynchronous, active-high.
- adc_data  in  64  packed samples; [15:0]=I0, [31:16]=Q0, [47:32]=I1, [63:48]=Q1.
- adc_valid  in  1  adc_data valid this cycle.
- adc_ovf  out  1  sticky overflow to ADC core.
- enable  in  1  capture enable, level.
- ant_sel  in  1  0 = antenna 0, 1 = antenna 1.
- decim_m1  in  4  decimation factor minus 1; 0 = keep every sample.
- m_data  out  32  {Q,I} sample to accelerator.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- ovf_cnt  out  16  dropped-sample count, saturating.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; FIFO emptied; adc_ovf=0, ovf_cnt=0, m_valid=0, m_data=0, fifo_level=0, busy=0; decimation counter=0.
- State machine (one-hot or binary):
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> IDLE when FIFO is empty.
  - DRAIN -> RUN when enable=1 again; FIFO contents are kept.
- On every IDLE->RUN transition:
  - latch ant_sel and decim_m1 into shadow registers; changes during RUN are ignored;
  - clear decim counter, adc_ovf and ovf_cnt.
- Capture in RUN only; adc_valid in IDLE/DRAIN is ignored.
  - On adc_valid: if cnt==0, the selected {Q,I} is a candidate and goes into the capture register.
  - cnt = (cnt==decim_shadow) ? 0 : cnt+1.
  - The first adc_valid after entering RUN is always kept. With decim_m1=3, samples 0,4,8,... are kept.
- Write: the capture register writes into the FIFO the cycle after capture.
- Latency: a kept sample on adc_valid at cycle N appears on m_data with m_valid=1 at cycle N+2 when the FIFO was empty. Show-ahead FIFO; m_data is registered.
- Handshake:
  - pop when m_valid & m_ready;
  - m_data/m_valid hold while m_ready=0;
  - m_valid never drops without a pop, except on reset.
- Full boundary:
  - write with FIFO full and no pop in the same cycle -> sample dropped, adc_ovf<=1, ovf_cnt+1 (saturates at 16'hFFFF);
  - write with FIFO full and a pop in the same cycle -> write accepted, no overflow.
- Empty boundary: a simultaneous write and pop on an empty FIFO cannot occur (m_valid=0), so occupancy goes to 1.
- Pointers wrap modulo 2^FIFO_AW. fifo_level = wr_ptr - rd_ptr using FIFO_AW+1-bit pointers; full when level == 2^FIFO_AW.
- Mid-operation reset aborts everything and discards FIFO contents; no partial outputs.

Optional Feature:
- Macro: ADC_RX_PACK_DC_REMOVE_EN.
- Defined:
  - per-component DC tracking, dc <= dc + ((x - dc) >>> 6), with 22-bit signed accumulator state;
  - the output is x - dc, saturated to a signed 16-bit value;
  - accumulators cleared on IDLE->RUN;
  - adds one pipeline stage, so latency is N+3.
- Undefined: samples pass unaltered and latency is N+2.

Decomposition:
- Package adc_rx_pack_pkg:
  - state encoding (IDLE, RUN, DRAIN);
  - field offsets I0/Q0/I1/Q1;
  - OVF_CNT_MAX;
  - DC_SHIFT=6.
- Sub-module rx_sync_fifo:
  - single-clock, show-ahead, parameterised by width/AW;
  - outputs full/empty/level;
  - reused elsewhere in the rx path.

Test Plan:
- Basic capture:
  - stimulus: reset; enable=1, ant_sel=0, decim_m1=0; 8 consecutive adc_valid with I0=k, Q0=0x100+k, m_ready=1;
  - required: m_data = {0x100+k, k} for k=0..7 in order; first one 2 cycles after the first adc_valid; no overflow.
- Antenna select and decimation:
  - stimulus: ant_sel=1, decim_m1=3, 16 samples with I1=k;
  - required: exactly 4 outputs with I=0,4,8,12.
- Mid-run config change:
  - stimulus: change decim_m1 from 3 to 0 mid-run;
  - required: still every 4th sample until enable toggles.
- Backpressure and overflow:
  - stimulus: m_ready=0, 20 kept samples;
  - required: fifo_level=16; adc_ovf=1; ovf_cnt=4; after m_ready=1, samples 0..15 drain intact.
- Full with simultaneous pop:
  - stimulus: FIFO full (16), then one cycle with m_ready=1 and a write;
  - required: level stays 16; ovf_cnt unchanged.
- Drain and reset:
  - stimulus: enable falls with 5 entries queued;
  - required: busy stays 1 until the 5th pop, then IDLE/busy=0.
  - stimulus: separately, assert adc_rst mid-stream;
  - required: m_valid=0, fifo_level=0, ovf_cnt=0 immediately (async).
